// File: rtl/version_pkg.sv
// rtl/version_pkg.sv - build identity, report character constants and nibble-to-ASCII helper
package version_pkg;

  // Version fields are binary; date/time fields are BCD.
  localparam logic [7:0]  C_VER_MAJOR    = 8'h00;
  localparam logic [7:0]  C_VER_MINOR    = 8'h00;
  localparam logic [7:0]  C_VER_PATCH    = 8'h00;
  localparam logic [7:0]  C_VER_BUILD    = 8'd74;
  localparam logic [15:0] C_BUILD_YEAR   = 16'h2026;
  localparam logic [7:0]  C_BUILD_MONTH  = 8'h01;
  localparam logic [7:0]  C_BUILD_DAY    = 8'h07;
  localparam logic [7:0]  C_BUILD_HOUR   = 8'h18;
  localparam logic [7:0]  C_BUILD_MINUTE = 8'h02;
  localparam logic [7:0]  C_BUILD_SECOND = 8'h42;

  localparam int C_REPORT_LEN_BASE = 32;

  localparam logic [7:0] C_CH_V     = 8'h56;
  localparam logic [7:0] C_CH_DOT   = 8'h2E;
  localparam logic [7:0] C_CH_SPACE = 8'h20;
  localparam logic [7:0] C_CH_DASH  = 8'h2D;
  localparam logic [7:0] C_CH_T     = 8'h54;
  localparam logic [7:0] C_CH_COLON = 8'h3A;
  localparam logic [7:0] C_CH_CR    = 8'h0D;
  localparam logic [7:0] C_CH_LF    = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/version_reporter_if.sv
// rtl/version_reporter_if.sv - byte stream from the reporter to a UART or debug sink
interface version_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/version_reporter.sv
// rtl/version_reporter.sv - serializes the build identity as an ASCII banner on a byte stream
module version_reporter
  import version_pkg::*;
#(
  parameter bit          EOL_CRLF = 1'b1,
  parameter logic [7:0]  MAJOR    = C_VER_MAJOR,
  parameter logic [7:0]  MINOR    = C_VER_MINOR,
  parameter logic [7:0]  PATCH    = C_VER_PATCH,
  parameter logic [7:0]  BUILD    = C_VER_BUILD,
  parameter logic [15:0] YEAR     = C_BUILD_YEAR,
  parameter logic [7:0]  MONTH    = C_BUILD_MONTH,
  parameter logic [7:0]  DAY      = C_BUILD_DAY,
  parameter logic [7:0]  HOUR     = C_BUILD_HOUR,
  parameter logic [7:0]  MINUTE   = C_BUILD_MINUTE,
  parameter logic [7:0]  SECOND   = C_BUILD_SECOND
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  output logic                busy,
  output logic                done,
  version_reporter_if.master  tx
);

  localparam int         LEN      = C_REPORT_LEN_BASE + (EOL_CRLF ? 2 : 0);
  localparam logic [5:0] LAST_IDX = 6'(LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t     state, state_nx;
  logic [5:0] idx, idx_nx;
  logic [7:0] byte_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Triggers are only honoured outside SEND, so a banner is never restarted mid-flight.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      S_IDLE, S_DONE: begin
        if (trigger) begin
          state_nx = S_SEND;
          idx_nx   = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SEND: begin
        if (tx.tx_ready) begin
          if (idx == LAST_IDX) begin
            state_nx = S_DONE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 6'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      6'd0:  byte_sel = C_CH_V;
      6'd1:  byte_sel = hex_ascii(MAJOR[7:4]);
      6'd2:  byte_sel = hex_ascii(MAJOR[3:0]);
      6'd3:  byte_sel = C_CH_DOT;
      6'd4:  byte_sel = hex_ascii(MINOR[7:4]);
      6'd5:  byte_sel = hex_ascii(MINOR[3:0]);
      6'd6:  byte_sel = C_CH_DOT;
      6'd7:  byte_sel = hex_ascii(PATCH[7:4]);
      6'd8:  byte_sel = hex_ascii(PATCH[3:0]);
      6'd9:  byte_sel = C_CH_DOT;
      6'd10: byte_sel = hex_ascii(BUILD[7:4]);
      6'd11: byte_sel = hex_ascii(BUILD[3:0]);
      6'd12: byte_sel = C_CH_SPACE;
      6'd13: byte_sel = hex_ascii(YEAR[15:12]);
      6'd14: byte_sel = hex_ascii(YEAR[11:8]);
      6'd15: byte_sel = hex_ascii(YEAR[7:4]);
      6'd16: byte_sel = hex_ascii(YEAR[3:0]);
      6'd17: byte_sel = C_CH_DASH;
      6'd18: byte_sel = hex_ascii(MONTH[7:4]);
      6'd19: byte_sel = hex_ascii(MONTH[3:0]);
      6'd20: byte_sel = C_CH_DASH;
      6'd21: byte_sel = hex_ascii(DAY[7:4]);
      6'd22: byte_sel = hex_ascii(DAY[3:0]);
      6'd23: byte_sel = C_CH_T;
      6'd24: byte_sel = hex_ascii(HOUR[7:4]);
      6'd25: byte_sel = hex_ascii(HOUR[3:0]);
      6'd26: byte_sel = C_CH_COLON;
      6'd27: byte_sel = hex_ascii(MINUTE[7:4]);
      6'd28: byte_sel = hex_ascii(MINUTE[3:0]);
      6'd29: byte_sel = C_CH_COLON;
      6'd30: byte_sel = hex_ascii(SECOND[7:4]);
      6'd31: byte_sel = hex_ascii(SECOND[3:0]);
      6'd32: byte_sel = C_CH_CR;
      6'd33: byte_sel = C_CH_LF;
      default: byte_sel = 8'h00;
    endcase
  end

  // Data depends only on registered state/index, never on tx_ready.
  assign busy        = (state == S_SEND);
  assign done        = (state == S_DONE);
  assign tx.tx_valid = (state == S_SEND);
  assign tx.tx_data  = (state == S_SEND) ? byte_sel : 8'h00;

endmodule

// File: tb/tb_version_reporter.sv
// tb/tb_version_reporter.sv - self-checking bench for version_reporter (CRLF and no-CRLF variants)
module tb_version_reporter;
  import version_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic trig_a = 1'b0, trig_b = 1'b0;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  version_reporter_if ifa ();
  version_reporter_if ifb ();
  assign ifa.tx_ready = ready_a;
  assign ifb.tx_ready = ready_b;

  version_reporter #(.EOL_CRLF(1'b1)) dut_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .busy(busy_a), .done(done_a), .tx(ifa.master)
  );

  version_reporter #(.EOL_CRLF(1'b0), .BUILD(8'hFF), .DAY(8'h3A)) dut_b (
    .clk(clk), .rst(rst), .trigger(trig_b), .busy(busy_b), .done(done_b), .tx(ifb.master)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: banner text built from field values with a digit lookup table.
  string digits = "0123456789ABCDEF";
  string exp_s[2];
  int    len_s[2];

  function automatic string hx(input logic [7:0] v);
    return $sformatf("%c%c", digits[v[7:4]], digits[v[3:0]]);
  endfunction

  function automatic string banner(input logic [7:0] maj, input logic [7:0] mnr, input logic [7:0] pat,
                                   input logic [7:0] bld, input logic [15:0] yr, input logic [7:0] mon,
                                   input logic [7:0] day, input logic [7:0] hr, input logic [7:0] mi,
                                   input logic [7:0] se, input bit crlf);
    string s;
    s = {"V", hx(maj), ".", hx(mnr), ".", hx(pat), ".", hx(bld), " ", hx(yr[15:8]), hx(yr[7:0]),
         "-", hx(mon), "-", hx(day), "T", hx(hr), ":", hx(mi), ":", hx(se)};
    if (crlf) s = {s, $sformatf("%c%c", 8'h0d, 8'h0a)};
    return s;
  endfunction

  function automatic logic vld(input int w);
    return (w == 0) ? ifa.tx_valid : ifb.tx_valid;
  endfunction
  function automatic logic [7:0] dat(input int w);
    return (w == 0) ? ifa.tx_data : ifb.tx_data;
  endfunction
  function automatic logic rdy(input int w);
    return (w == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic bsy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic dn(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  task automatic set_trig(input int w, input logic v);
    if (w == 0) trig_a = v;
    else trig_b = v;
  endtask

  // Ready modes: 0 low, 1 high, 2 random ~30% high.
  int mode[2] = '{1, 1};
  always begin
    @(posedge clk);
    #1;
    ready_a = (mode[0] == 1) ? 1'b1 : (mode[0] == 2) ? ($urandom_range(0, 9) < 3) : 1'b0;
    ready_b = (mode[1] == 1) ? 1'b1 : (mode[1] == 2) ? ($urandom_range(0, 9) < 3) : 1'b0;
  end

  // Compare process: every cycle, against the model and the stall rules.
  int         pos[2]      = '{0, 0};
  int         done_cnt[2] = '{0, 0};
  bit         stall_prev[2] = '{0, 0};
  logic [7:0] prev_d[2];
  logic [7:0] last_hs[2];

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        pos[w] = 0;
        stall_prev[w] = 0;
      end else begin
        if (stall_prev[w]) begin
          chk("stall_valid_held", vld(w), 1);
          chk("stall_data_held", dat(w), prev_d[w]);
        end
        chk("busy_matches_valid", bsy(w), vld(w));
        if (vld(w)) begin
          if (pos[w] < len_s[w]) chk("banner_byte", dat(w), exp_s[w][pos[w]]);
          else chk("byte_overrun", pos[w], len_s[w] - 1);
        end
        if (dn(w)) begin
          chk("done_after_last_byte", pos[w], len_s[w]);
          chk("done_valid_low", vld(w), 0);
          pos[w] = 0;
          done_cnt[w]++;
        end
        if (vld(w) && rdy(w)) begin
          last_hs[w] = dat(w);
          pos[w]++;
        end
        stall_prev[w] = vld(w) && !rdy(w);
        prev_d[w] = dat(w);
      end
    end
  end

  // Runs one banner; returns edges from trigger sample to DONE (or stops at abort_at).
  task automatic run_banner(input int w, input bit inject, input bit restart, input int abort_at,
                            output int n);
    int len;
    int k;
    len = len_s[w];
    @(posedge clk); #1 set_trig(w, 1'b1);
    @(posedge clk); #1 set_trig(w, 1'b0);
    @(negedge clk);
    chk("start_valid", vld(w), 1);
    chk("start_data_V", dat(w), 8'h56);
    chk("start_busy", bsy(w), 1);
    n = 0;
    while (!dn(w) && n != abort_at && n < 3000) begin
      set_trig(w, (inject && (n + 1 == 6 || n + 1 == len)) ? 1'b1 : 1'b0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    set_trig(w, 1'b0);
    if (n == abort_at) return;
    if (n >= 3000) begin
      chk("done_timeout", 0, 1);
      return;
    end
    if (restart) begin
      set_trig(w, 1'b1);
      @(posedge clk); #1 set_trig(w, 1'b0);
      @(negedge clk);
      chk("restart_valid", vld(w), 1);
      chk("restart_data_V", dat(w), 8'h56);
      k = 0;
      while (!dn(w) && k < 3000) begin
        @(negedge clk);
        k++;
      end
      if (k >= 3000) chk("restart_done_timeout", 0, 1);
    end
    @(negedge clk);
    chk("done_one_cycle", dn(w), 0);
    chk("idle_after_done", vld(w), 0);
  endtask

  int n;
  int dc;

  initial begin
    rst = 1'b1;
    exp_s[0] = banner(8'h00, 8'h00, 8'h00, 8'd74, 16'h2026, 8'h01, 8'h07, 8'h18, 8'h02, 8'h42, 1'b1);
    exp_s[1] = banner(8'h00, 8'h00, 8'h00, 8'hFF, 16'h2026, 8'h01, 8'h3A, 8'h18, 8'h02, 8'h42, 1'b0);
    len_s[0] = exp_s[0].len();
    len_s[1] = exp_s[1].len();

    // Hand-computed pins on the model itself.
    chk("model_len_crlf", len_s[0], 34);
    chk("model_len_nocrlf", len_s[1], 32);
    chk("model_b0", exp_s[0][0], 8'h56);
    chk("model_build_hi", exp_s[0][10], 8'h34);
    chk("model_build_lo", exp_s[0][11], 8'h41);
    chk("model_year_2", exp_s[0][13], 8'h32);
    chk("model_lf", exp_s[0][33], 8'h0A);
    chk("model_last_nocrlf", exp_s[1][31], 8'h32);
    chk("model_ff_hi", exp_s[1][10], 8'h46);
    chk("model_ff_lo", exp_s[1][11], 8'h46);
    chk("model_day3_hi", exp_s[1][21], 8'h33);
    chk("model_dayA_lo", exp_s[1][22], 8'h41);

    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("reset_valid", vld(w), 0);
      chk("reset_busy", bsy(w), 0);
      chk("reset_done", dn(w), 0);
      chk("reset_data", dat(w), 8'h00);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Full banner without backpressure.
    run_banner(0, 1'b0, 1'b0, -1, n);
    chk("cycles_full_crlf", n, 34);
    chk("last_byte_lf", last_hs[0], 8'h0A);

    // No-CRLF variant with out-of-range BCD day and FF build.
    run_banner(1, 1'b0, 1'b0, -1, n);
    chk("cycles_full_nocrlf", n, 32);
    chk("last_byte_nocrlf", last_hs[1], 8'h32);

    // Random backpressure.
    mode[0] = 2;
    dc = done_cnt[0];
    run_banner(0, 1'b0, 1'b0, -1, n);
    chk("bp_one_done", done_cnt[0] - dc, 1);
    chk("bp_not_faster", (n >= 34) ? 1 : 0, 1);
    mode[0] = 1;
    repeat (2) @(negedge clk);

    // Triggers at index 5 and at the final handshake are ignored.
    dc = done_cnt[0];
    run_banner(0, 1'b1, 1'b0, -1, n);
    chk("ignored_trig_cycles", n, 34);
    repeat (3) @(negedge clk);
    chk("ignored_trig_one_done", done_cnt[0] - dc, 1);
    chk("ignored_trig_idle", vld(0), 0);

    // Trigger in the DONE cycle restarts immediately.
    dc = done_cnt[0];
    run_banner(0, 1'b0, 1'b1, -1, n);
    chk("restart_two_dones", done_cnt[0] - dc, 2);

    // Asynchronous reset mid-stream at index 17.
    run_banner(0, 1'b0, 1'b0, 17, n);
    chk("abort_precond_valid", vld(0), 1);
    chk("abort_precond_dash", dat(0), 8'h2D);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", vld(0), 0);
    chk("abort_busy", bsy(0), 0);
    chk("abort_done", dn(0), 0);
    chk("abort_data", dat(0), 8'h00);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    run_banner(0, 1'b0, 1'b0, -1, n);
    chk("after_abort_cycles", n, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/version_reporter.md
# version_reporter

Serializes the build identity held in `version_pkg` as a fixed-format ASCII banner onto a byte stream. Sits directly downstream of `version_pkg` and upstream of the UART transmitter or debug byte sink. A single trigger pulse emits the banner one byte per accepted handshake. Example banner for version 0.0.0.74 built 2026-01-07 18:02:42: `V00.00.00.4A 2026-01-07T18:02:42` followed by CR LF.

## Interface
- `EOL_CRLF`, default 1: 1 appends CR (0x0D) and LF (0x0A), giving 34 bytes; 0 omits them, giving 32 bytes.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous and active-high.
- `trigger` in 1: single-cycle request to emit the banner.
- `busy` out 1: high while a banner is in progress.
- `done` out 1: one-cycle pulse after the last byte is accepted.
- `tx_data` out 8: current ASCII byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the sink accepts the byte when `tx_valid && tx_ready`.

## Operation
- **FSM states:** IDLE, SEND, DONE. A byte index counter (6 bits) runs 0..LEN-1.
- **Leaving IDLE or DONE:** `trigger` moves the FSM to SEND with index = 0. Without `trigger`, DONE returns to IDLE.
- **In SEND:**
  - On a handshake with index < LEN-1, the index increments.
  - On a handshake with index = LEN-1, the FSM goes to DONE.
- **Banner byte order:**
  - 'V', then MAJOR as 2 hex digits, '.', MINOR, '.', PATCH, '.', BUILD (indices 0–11).
  - ' ', then YEAR as 4 digits, '-', MONTH, '-', DAY (12–22).
  - 'T', then HOUR, ':', MINUTE, ':', SECOND (23–31).
  - CR, LF (32–33), only when `EOL_CRLF` = 1.
- **Digit conversion:** every field is emitted nibble by nibble, MS nibble first. Nibble 0–9 maps to 0x30–0x39; nibble A–F maps to 0x41–0x46 (uppercase).
  - Version fields are binary, so they appear as hex (74 → "4A").
  - Date fields are BCD, so they appear as decimal.
  - An out-of-range BCD nibble is emitted as-is, as a hex letter; it is not flagged.
- **Ignored triggers:** `trigger` is ignored in SEND, including in the cycle of the final handshake. It is not queued.
- **Output stability:** `tx_data` stays stable while `tx_valid && !tx_ready`. `tx_valid` never deasserts in SEND without a handshake.
- **`done` and `busy`:** `done` is high only in DONE. `busy` is high only in SEND.

## Timing
- **Reset values:** IDLE, index 0, `busy` = 0, `done` = 0, `tx_valid` = 0, `tx_data` = 0x00.
- **Asserting reset mid-banner:** aborts immediately (asynchronous). Outputs return to their reset values with no partial-byte completion.
- **Release from reset:** the first `trigger` is sampled on the first rising edge after release.
- **Start latency:** `trigger` sampled at edge N gives `tx_valid` = 1, `tx_data` = 'V', `busy` = 1 after edge N, i.e. one cycle.
- **Throughput:** one byte per cycle when `tx_ready` is held high. With ready always high, the banner completes in LEN cycles.
- **End of banner:** the last handshake at edge M gives `done` = 1, `busy` = 0, `tx_valid` = 0 in the cycle after M.
  - If `trigger` is sampled during that DONE cycle, SEND restarts at the next edge.
  - The minimum trigger-to-trigger spacing is therefore LEN+1 cycles.
- **Combinational paths:** `tx_data` is a registered output, or a mux driven only by registered state. There is no combinational path from `tx_ready` to `tx_data`/`tx_valid`.

## Structure
- Add to `version_pkg`:
  - `C_REPORT_LEN_BASE` = 32.
  - Character constants: 'V', '.', ' ', '-', 'T', ':', CR, LF.
  - A `hex_ascii` function (4-bit in, 8-bit out) for reuse by other report blocks.
- The FSM state enum lives locally in the module.
- No sub-module: the byte selection is a case on the index over the package constants.

## Test plan
- **Full banner, no backpressure:** reset, `tx_ready` = 1, pulse `trigger` → 34 bytes 0x56 0x30 0x30 0x2E … 0x34 0x41 0x20 0x32 0x30 0x32 0x36 … 0x0D 0x0A on consecutive cycles, then `done` for 1 cycle.
- **Random backpressure (`tx_ready` 30% high):** → identical byte sequence; `tx_data` is unchanged across every stalled cycle; `tx_valid` never drops mid-banner.
- **`EOL_CRLF` = 0:** → exactly 32 bytes; the last byte is 0x32 ('2' of seconds 42).
- **Trigger while busy:** pulse at index 5 and again in the final-handshake cycle → exactly one banner and one `done`. A `trigger` in the DONE cycle → a second banner starts the next cycle.
- **Reset mid-stream:** assert `rst` at index 17 with `tx_valid` high → `tx_valid`, `busy`, `done` go to 0 immediately. The next `trigger` restarts from 'V'.
- **Digit mapping:** force a package variant with BUILD = 8'hFF and DAY = 8'h3A → bytes "FF" (0x46 0x46) and "3A" (0x33 0x41).
